// File: rtl/trap_fifo_if.sv
// Trap-buffer bus bundle: Z80 bus snoop, trap strobe, supervisor record-read port.
// master drives the bus side (CPU/mapper decode); slave is the trap buffer.
interface trap_fifo_if;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        rd_n;
  logic        wr_n;
  logic        trap_addr_wr_n;
  logic        rec_rd_n;
  logic [1:0]  rec_sel;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        trap_pending;
  logic        overflow;

  modport master (
    output addr, data_in, rd_n, wr_n, trap_addr_wr_n, rec_rd_n, rec_sel,
    input  data_out, data_oe, trap_pending, overflow
  );

  modport slave (
    input  addr, data_in, rd_n, wr_n, trap_addr_wr_n, rec_rd_n, rec_sel,
    output data_out, data_oe, trap_pending, overflow
  );
endinterface

// File: rtl/trap_fifo.sv
// Trap-record FIFO: one record per trapped I/O access, visible right after the capture edge.
// No backpressure: a capture into a full FIFO (without a same-edge pop) is dropped and flagged sticky overflow.
module trap_fifo #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       reset_n,
  trap_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]       DEPTH_C = 3'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  dat;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             armed_q, armed_d;
  logic             overflow_q, overflow_d;
  logic             rd_seen_q, rd_seen_d;
  logic [1:0]       sel_q, sel_d;

  logic capture, empty, full, end_rd, pop, push, ovf_set, ovf_clr;
  rec_t new_rec, head;

  always_comb begin
    capture = armed_q && !bus.trap_addr_wr_n && (!bus.rd_n || !bus.wr_n);
    empty   = (count_q == 3'd0);
    full    = (count_q == DEPTH_C);
    end_rd  = rd_seen_q && bus.rec_rd_n;
    pop     = end_rd && (sel_q == 2'd3) && !empty;
    // A pop on the same edge frees the slot the push needs.
    push    = capture && (!full || pop);
    ovf_set = capture && full && !pop;
    ovf_clr = end_rd && (sel_q == 2'd0);

    new_rec.dir  = !bus.wr_n;
    new_rec.addr = bus.addr;
    new_rec.dat  = !bus.wr_n ? bus.data_in : 8'hFF;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    armed_d    = armed_q;
    overflow_d = overflow_q;

    if (capture)
      armed_d = 1'b0;
    else if (bus.trap_addr_wr_n)
      armed_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d = count_q + 3'(push) - 3'(pop);

    if (ovf_set)
      overflow_d = 1'b1;
    else if (ovf_clr)
      overflow_d = 1'b0;

    rd_seen_d = !bus.rec_rd_n;
    sel_d     = bus.rec_rd_n ? sel_q : bus.rec_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      sel_q      <= 2'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      rd_seen_q  <= rd_seen_d;
      sel_q      <= sel_d;
    end
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    case (bus.rec_sel)
      2'd0:    bus.data_out = {1'b0, count_q, head.dir & !empty, overflow_q, full, !empty};
      2'd1:    bus.data_out = empty ? 8'hFF : head.addr[7:0];
      2'd2:    bus.data_out = empty ? 8'hFF : head.addr[15:8];
      default: bus.data_out = empty ? 8'hFF : head.dat;
    endcase
  end

  assign bus.data_oe      = !bus.rec_rd_n;
  assign bus.trap_pending = !empty;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_trap_fifo.sv
// Directed bench for trap_fifo (DEPTH=4): capture, wait states, overflow, same-edge push/pop, reset.
module tb_trap_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tp_seen;
  logic [7:0] rd;

  trap_fifo_if bus();

  trap_fifo #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One trapped access held for 1+waits sampled edges, then one idle edge to re-arm.
  task automatic io_access(input logic [15:0] a, input logic [7:0] d, input bit is_out, input int waits);
    @(negedge clk);
    bus.addr = a;
    bus.data_in = d;
    bus.trap_addr_wr_n = 1'b0;
    if (is_out) bus.wr_n = 1'b0;
    else        bus.rd_n = 1'b0;
    @(posedge clk);
    #1 tp_seen = bus.trap_pending;
    repeat (waits) @(posedge clk);
    @(negedge clk);
    bus.trap_addr_wr_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    @(negedge clk);
  endtask

  // Supervisor register read: data sampled mid-read; commit lands on the edge after rec_rd_n rises.
  task automatic reg_read(input logic [1:0] sel, output logic [7:0] d);
    @(negedge clk);
    bus.rec_sel = sel;
    bus.rec_rd_n = 1'b0;
    #1 d = bus.data_out;
    check("data_oe_during_read", bus.data_oe, 1);
    @(negedge clk);
    bus.rec_rd_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.addr = 16'h0000;
    bus.data_in = 8'h00;
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.trap_addr_wr_n = 1'b1;
    bus.rec_rd_n = 1'b1;
    bus.rec_sel = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_trap_pending", bus.trap_pending, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_data_oe", bus.data_oe, 0);
    reset_n = 1'b1;
    @(negedge clk);
    reg_read(2'd0, rd); check("rst_status", rd, 8'h00);

    // OUT (C),A with BC=12A5, A=3C
    io_access(16'h12A5, 8'h3C, 1'b1, 0);
    check("out_pending_after_edge", tp_seen, 1);
    reg_read(2'd0, rd); check("out_status", rd, 8'h19);
    reg_read(2'd1, rd); check("out_addr_lo", rd, 8'hA5);
    reg_read(2'd2, rd); check("out_addr_hi", rd, 8'h12);
    reg_read(2'd3, rd); check("out_data", rd, 8'h3C);
    reg_read(2'd0, rd); check("out_status_after_pop", rd, 8'h00);
    check("out_pending_after_pop", bus.trap_pending, 0);

    // IN with 3 wait states: one record only
    io_access(16'h40FE, 8'h77, 1'b0, 3);
    reg_read(2'd0, rd); check("in_status", rd, 8'h11);
    reg_read(2'd1, rd); check("in_addr_lo", rd, 8'hFE);
    reg_read(2'd2, rd); check("in_addr_hi", rd, 8'h40);
    reg_read(2'd3, rd); check("in_data", rd, 8'hFF);
    reg_read(2'd0, rd); check("in_status_after_pop", rd, 8'h00);

    // Five OUTs into a 4-deep FIFO
    for (int i = 1; i <= 5; i++)
      io_access(16'(i), 8'(i * 17), 1'b1, 0);
    check("ovf_output", bus.overflow, 1);
    reg_read(2'd0, rd); check("ovf_status", rd, 8'h4F);
    reg_read(2'd0, rd); check("ovf_status_cleared", rd, 8'h4B);
    for (int i = 1; i <= 4; i++) begin
      reg_read(2'd1, rd); check($sformatf("ovf_pop_addr%0d", i), rd, 32'(i));
      reg_read(2'd3, rd); check($sformatf("ovf_pop_data%0d", i), rd, 32'(i * 17));
    end
    reg_read(2'd0, rd); check("ovf_drained_status", rd, 8'h00);

    // Full FIFO: pop completes on the same edge as a new capture
    for (int i = 0; i < 4; i++)
      io_access(16'h0010 + 16'(i), 8'hA0 + 8'(i), 1'b1, 0);
    @(negedge clk);
    bus.rec_sel = 2'd3;
    bus.rec_rd_n = 1'b0;
    #1 rd = bus.data_out;
    check("sim_popped_data", rd, 8'hA0);
    @(negedge clk);
    bus.rec_rd_n = 1'b1;
    bus.addr = 16'h0077;
    bus.data_in = 8'h5A;
    bus.wr_n = 1'b0;
    bus.trap_addr_wr_n = 1'b0;
    @(negedge clk);
    bus.wr_n = 1'b1;
    bus.trap_addr_wr_n = 1'b1;
    @(negedge clk);
    check("sim_overflow", bus.overflow, 0);
    reg_read(2'd0, rd); check("sim_status", rd, 8'h4B);
    for (int i = 1; i < 4; i++) begin
      reg_read(2'd1, rd); check($sformatf("sim_head_addr%0d", i), rd, 32'h10 + 32'(i));
      reg_read(2'd3, rd); check($sformatf("sim_head_data%0d", i), rd, 32'hA0 + 32'(i));
    end
    reg_read(2'd1, rd); check("sim_last_addr", rd, 8'h77);
    reg_read(2'd3, rd); check("sim_last_data", rd, 8'h5A);
    reg_read(2'd0, rd); check("sim_drained_status", rd, 8'h00);

    // Reset mid-FIFO with the violation line held low
    for (int i = 1; i <= 3; i++)
      io_access(16'h0020 + 16'(i), 8'h30 + 8'(i), 1'b1, 0);
    reg_read(2'd0, rd); check("mid_status_before_reset", rd, 8'h39);
    @(negedge clk);
    bus.trap_addr_wr_n = 1'b0;
    bus.addr = 16'h0099;
    bus.data_in = 8'hC3;
    #2 reset_n = 1'b0;
    @(negedge clk);
    bus.wr_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_pending_after_reset", bus.trap_pending, 0);
    reg_read(2'd0, rd); check("mid_status_after_reset", rd, 8'h00);
    check("mid_no_capture_while_low", bus.trap_pending, 0);
    @(negedge clk);
    bus.wr_n = 1'b1;
    bus.trap_addr_wr_n = 1'b1;
    @(negedge clk);
    check("mid_still_empty_after_release", bus.trap_pending, 0);
    io_access(16'h0042, 8'h24, 1'b1, 0);
    reg_read(2'd0, rd); check("mid_rearmed_status", rd, 8'h19);
    reg_read(2'd1, rd); check("mid_rearmed_addr", rd, 8'h42);
    reg_read(2'd3, rd); check("mid_rearmed_data", rd, 8'h24);

    // Pop attempts on an empty FIFO
    reg_read(2'd3, rd); check("empty_pop_data", rd, 8'hFF);
    reg_read(2'd1, rd); check("empty_addr_lo", rd, 8'hFF);
    reg_read(2'd0, rd); check("empty_status", rd, 8'h00);
    io_access(16'h5566, 8'h99, 1'b1, 0);
    reg_read(2'd2, rd); check("empty_ptr_addr_hi", rd, 8'h55);
    reg_read(2'd3, rd); check("empty_ptr_data", rd, 8'h99);
    check("idle_data_oe", bus.data_oe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
